// File: rtl/fir_ctrl_if.sv
// AXI-lite bundle between the host and the FIR controller's register and tap space.
interface fir_ctrl_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_ctrl.sv
// FIR accelerator control registers, start/done/idle sequencing and tap BRAM arbitration.
// Optional reject counter at 0x14 is built when FIR_CTRL_REJCNT_EN is defined.
module fir_ctrl #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  fir_ctrl_if.slave              axil,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   eng_tap_rd,
  input  logic [3:0]             eng_tap_idx,
  output logic [pDATA_WIDTH-1:0] eng_tap_data,
  output logic                   ap_start_o,
  output logic [pDATA_WIDTH-1:0] len_o,
  input  logic                   eng_done
);

  localparam logic [pADDR_WIDTH-1:0] AddrCtrl = pADDR_WIDTH'('h00);
  localparam logic [pADDR_WIDTH-1:0] AddrLen  = pADDR_WIDTH'('h10);
  localparam logic [pADDR_WIDTH-1:0] AddrRej  = pADDR_WIDTH'('h14);
  localparam logic [pADDR_WIDTH-1:0] TapBase  = pADDR_WIDTH'('h40);
  localparam logic [pADDR_WIDTH-1:0] TapLast  = pADDR_WIDTH'(32'h40 + 4 * Tape_Num - 4);

  typedef enum logic [1:0] {RIdle, RFetch, RCapt, RResp} rstate_e;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TapBase) && (a <= TapLast) && (a[1:0] == 2'b00);
  endfunction

  rstate_e                rstate_q, rstate_d;
  logic                   rpend_q, rpend_d;
  logic [pADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic [pDATA_WIDTH-1:0] reg_rdata;

  logic busy, wr_hs, ar_hs, wr_tap, wr_start, wr_len;

  assign busy     = ~ap_idle_q;
  assign wr_hs    = axil.awvalid & axil.wvalid & (rstate_q != RFetch);
  assign ar_hs    = axil.arvalid & axil.arready;
  assign wr_tap   = wr_hs & is_tap(axil.awaddr);
  assign wr_start = wr_hs & (axil.awaddr == AddrCtrl) & axil.wdata[0];
  assign wr_len   = wr_hs & (axil.awaddr == AddrLen);

  assign axil.awready = wr_hs;
  assign axil.wready  = wr_hs;
  // A pending tap read holds off further AR handshakes until it has fetched.
  assign axil.arready = (rstate_q == RIdle) & ~rpend_q;
  assign axil.rvalid  = (rstate_q == RResp);
  assign axil.rdata   = rdata_q;

  assign ap_start_o   = ap_start_q;
  assign len_o        = len_q;
  assign eng_tap_data = tap_Do;

`ifdef FIR_CTRL_REJCNT_EN
  logic       wr_drop;
  logic [7:0] rej_q, rej_d;

  assign wr_drop = busy & (wr_start | wr_len | wr_tap);

  always_comb begin
    rej_d = rej_q;
    if (ar_hs && (axil.araddr == AddrRej)) rej_d = '0;
    if (wr_drop && (rej_d != 8'hFF)) rej_d = rej_d + 8'd1;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) rej_q <= '0;
    else             rej_q <= rej_d;
  end
`endif

  always_comb begin
    reg_rdata = '0;
    case (axil.araddr)
      AddrCtrl: reg_rdata[2:0] = {ap_idle_q, ap_done_q, ap_start_q};
      AddrLen:  reg_rdata      = len_q;
`ifdef FIR_CTRL_REJCNT_EN
      AddrRej:  reg_rdata[7:0] = rej_q;
`endif
      default:  reg_rdata      = '0;
    endcase
  end

  // ap_ctrl: the read-clear of ap_done loses to a coincident eng_done.
  always_comb begin
    ap_start_d = 1'b0;
    ap_done_d  = ap_done_q;
    ap_idle_d  = ap_idle_q;
    len_d      = len_q;
    if (ar_hs && (axil.araddr == AddrCtrl)) ap_done_d = 1'b0;
    if (eng_done) begin
      ap_done_d = 1'b1;
      ap_idle_d = 1'b1;
    end
    if (wr_start && !busy) begin
      ap_start_d = 1'b1;
      ap_idle_d  = 1'b0;
      ap_done_d  = 1'b0;
    end
    if (wr_len && !busy) len_d = axil.wdata;
  end

  always_comb begin
    rstate_d = rstate_q;
    rpend_d  = rpend_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    unique case (rstate_q)
      RIdle: begin
        if (ar_hs) begin
          raddr_d = axil.araddr;
          if (!is_tap(axil.araddr)) begin
            rdata_d  = reg_rdata;
            rstate_d = RResp;
          end else if (busy) begin
            rdata_d  = '1;
            rstate_d = RResp;
          end else if (wr_hs) begin
            rpend_d = 1'b1;
          end else begin
            rstate_d = RFetch;
          end
        end else if (rpend_q && !wr_hs) begin
          // Ownership may have passed to the engine while the read waited.
          rpend_d = 1'b0;
          if (busy) begin
            rdata_d  = '1;
            rstate_d = RResp;
          end else begin
            rstate_d = RFetch;
          end
        end
      end
      RFetch: rstate_d = RCapt;
      RCapt: begin
        rdata_d  = tap_Do;
        rstate_d = RResp;
      end
      RResp: if (axil.rready) rstate_d = RIdle;
      default: rstate_d = RIdle;
    endcase
  end

  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (busy) begin
      tap_EN = eng_tap_rd;
      tap_A  = pADDR_WIDTH'({eng_tap_idx, 2'b00});
    end else if (wr_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = axil.awaddr - TapBase;
      tap_Di = axil.wdata;
    end else if (rstate_q == RFetch) begin
      tap_EN = 1'b1;
      tap_A  = raddr_q - TapBase;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rstate_q   <= RIdle;
      rpend_q    <= 1'b0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
      len_q      <= '0;
    end else begin
      rstate_q   <= rstate_d;
      rpend_q    <= rpend_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      ap_start_q <= ap_start_d;
      ap_done_q  <= ap_done_d;
      ap_idle_q  <= ap_idle_d;
      len_q      <= len_d;
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: vector table of AXI-lite accesses plus hand sequences for busy/done/reset.
module tb_fir_ctrl;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    int          lat;
    logic [3:0]  we;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

`ifdef FIR_CTRL_REJCNT_EN
  localparam bit RejEn = 1'b1;
`else
  localparam bit RejEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;
  logic        eng_tap_rd = 1'b0;
  logic [3:0]  eng_tap_idx = '0;
  logic [31:0] eng_tap_data;
  logic        ap_start_o;
  logic [31:0] len_o;
  logic        eng_done = 1'b0;
  logic [31:0] mem [16] = '{default: '0};

  int checks = 0;
  int failures = 0;
  int start_pulses = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  fir_ctrl_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) axil ();

  fir_ctrl dut (
    .axis_clk     (clk),
    .axis_rst_n   (rst_n),
    .axil         (axil),
    .tap_WE       (tap_WE),
    .tap_EN       (tap_EN),
    .tap_Di       (tap_Di),
    .tap_A        (tap_A),
    .tap_Do       (tap_Do),
    .eng_tap_rd   (eng_tap_rd),
    .eng_tap_idx  (eng_tap_idx),
    .eng_tap_data (eng_tap_data),
    .ap_start_o   (ap_start_o),
    .len_o        (len_o),
    .eng_done     (eng_done)
  );

  always #5 clk = ~clk;

  // Registered-read single-port BRAM.
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  always @(posedge clk) if (ap_start_o) start_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] we);
    int n;
    @(negedge clk);
    axil.awvalid = 1'b1;
    axil.wvalid  = 1'b1;
    axil.awaddr  = a;
    axil.wdata   = d;
    #1;
    n = 0;
    while (!axil.awready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("wr%03h awready", a), 32'(axil.awready & axil.wready), 32'd1);
    check($sformatf("wr%03h tap_WE", a), 32'(tap_WE), 32'(we));
    if (we == 4'hF) begin
      check($sformatf("wr%03h tap_A", a), 32'(tap_A), 32'(a - 12'h40));
      check($sformatf("wr%03h tap_Di", a), tap_Di, d);
    end
    @(posedge clk);
    #1;
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
  endtask

  task automatic axil_read(input logic [11:0] a, input logic [31:0] exp, input int lat,
                           input string name);
    int   n;
    exp_t e;
    e.data = exp;
    e.lat  = lat;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    axil.arvalid = 1'b1;
    axil.araddr  = a;
    #1;
    n = 0;
    while (!axil.arready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    axil.arvalid = 1'b0;
    n = 1;
    while (!axil.rvalid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb_q.pop_front();
    if (!axil.rvalid) begin
      checks++;
      failures++;
      $display("FAIL %s rvalid actual=0 expected=1 within %0d cycles", e.name, n);
    end else begin
      check({e.name, " rdata"}, axil.rdata, e.data);
      if (e.lat != 0) check({e.name, " latency"}, 32'(n), 32'(e.lat));
    end
    axil.rready = 1'b1;
    @(posedge clk);
    #1;
    axil.rready = 1'b0;
  endtask

  task automatic add_vec(input bit wr, input logic [11:0] a, input logic [31:0] d,
                         input int lat, input logic [3:0] we);
    vec_t v;
    v.wr   = wr;
    v.addr = a;
    v.data = d;
    v.lat  = lat;
    v.we   = we;
    vecs.push_back(v);
  endtask

  initial begin
    int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    add_vec(1'b0, 12'h000, 32'h4, 1, 4'h0);
    add_vec(1'b0, 12'h010, 32'h0, 1, 4'h0);
    add_vec(1'b0, 12'h014, 32'h0, 1, 4'h0);
    add_vec(1'b0, 12'h020, 32'h0, 1, 4'h0);
    add_vec(1'b1, 12'h030, 32'hDEAD, 0, 4'h0);
    for (int i = 0; i < 11; i++) add_vec(1'b1, 12'(12'h40 + 4 * i), 32'(taps[i]), 0, 4'hF);
    for (int i = 0; i < 11; i++) add_vec(1'b0, 12'(12'h40 + 4 * i), 32'(taps[i]), 3, 4'h0);
    add_vec(1'b0, 12'h030, 32'h0, 1, 4'h0);
    add_vec(1'b1, 12'h010, 32'd600, 0, 4'h0);
    add_vec(1'b0, 12'h010, 32'd600, 1, 4'h0);

    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    axil.arvalid = 1'b0;
    axil.rready  = 1'b0;
    axil.awaddr  = '0;
    axil.wdata   = '0;
    axil.araddr  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst awready", 32'(axil.awready), 32'd0);
    check("rst rvalid", 32'(axil.rvalid), 32'd0);
    check("rst rdata", axil.rdata, 32'd0);
    check("rst tap_EN", 32'(tap_EN), 32'd0);
    check("rst tap_WE", 32'(tap_WE), 32'd0);
    check("rst tap_A", 32'(tap_A), 32'd0);
    check("rst tap_Di", tap_Di, 32'd0);
    check("rst ap_start_o", 32'(ap_start_o), 32'd0);
    check("rst len_o", len_o, 32'd0);
    check("rst eng_tap_data", eng_tap_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) axil_write(vecs[i].addr, vecs[i].data, vecs[i].we);
      else axil_read(vecs[i].addr, vecs[i].data, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Start: one-cycle pulse right after the write handshake.
    axil_write(12'h000, 32'h1, 4'h0);
    check("start pulse high", 32'(ap_start_o), 32'd1);
    check("len_o", len_o, 32'd600);
    @(posedge clk);
    #1;
    check("start pulse low", 32'(ap_start_o), 32'd0);
    axil_read(12'h000, 32'h0, 1, "ctrl busy");

    // Busy lock.
    axil_write(12'h04C, 32'd99, 4'h0);
    axil_read(12'h04C, 32'hFFFF_FFFF, 1, "busy tap read");
    axil_read(12'h014, RejEn ? 32'd1 : 32'd0, 1, "rejcnt one");
    axil_write(12'h010, 32'd5, 4'h0);
    axil_write(12'h000, 32'h1, 4'h0);
    check("len_o locked", len_o, 32'd600);
    check("start pulses busy", 32'(start_pulses), 32'd1);

    @(negedge clk);
    eng_tap_rd  = 1'b1;
    eng_tap_idx = 4'd5;
    #1;
    check("eng tap_EN", 32'(tap_EN), 32'd1);
    check("eng tap_A", 32'(tap_A), 32'd20);
    @(posedge clk);
    #1;
    check("eng_tap_data", eng_tap_data, 32'd63);
    eng_tap_rd = 1'b0;

    // Done and read-clear.
    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    axil_read(12'h000, 32'h6, 1, "ctrl done");
    axil_read(12'h000, 32'h4, 1, "ctrl cleared");
    axil_read(12'h04C, 32'd23, 3, "tap3 kept");
    axil_read(12'h014, RejEn ? 32'd2 : 32'd0, 1, "rejcnt two");
    axil_read(12'h014, 32'd0, 1, "rejcnt cleared");

    fork
      axil_read(12'h000, 32'h4, 1, "ctrl coincident");
      begin
        @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
      end
    join
    axil_read(12'h000, 32'h6, 1, "ctrl after coincident");

    // Same-cycle tap write and read of the same tap.
    fork
      axil_write(12'h05C, 32'd77, 4'hF);
      axil_read(12'h05C, 32'd77, 0, "wr/rd same cycle");
    join
    axil_read(12'h058, 32'd56, 3, "tap6 intact");

    // Reset asserted while the read FSM is fetching.
    @(negedge clk);
    axil.arvalid = 1'b1;
    axil.araddr  = 12'h044;
    @(posedge clk);
    #1;
    axil.arvalid = 1'b0;
    check("fetch tap_EN", 32'(tap_EN), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst mid rvalid", 32'(axil.rvalid), 32'd0);
    check("rst mid len_o", len_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    axil_read(12'h000, 32'h4, 1, "ctrl after reset");
    axil_read(12'h044, 32'hFFFF_FFF6, 3, "tap1 after reset");
    check("start pulses total", 32'(start_pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
